// File: rtl/uart_rx_core.sv
// UART receive datapath: 16x oversampled deserialiser for 5-8 data bits,
// optional even parity and 1-3 stop bits, with a one-cycle valid pulse.
module uart_rx_core #(
    parameter int unsigned TOP_CLK_FREQ_HZ = 32'd50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       enable_i,
    input  logic [1:0] baud_sel_i,
    input  logic       parity_en_i,
    input  logic [1:0] stop_cfg_i,
    input  logic [1:0] data_cfg_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Rounded divisor from system clock to 16x the baud rate.
    function automatic logic [15:0] div_for(input logic [31:0] baud);
        logic [31:0] quot;
        quot = (TOP_CLK_FREQ_HZ + (baud << 3)) / (baud << 4);
        return quot[15:0];
    endfunction

    // Nonzero when the data bits plus the received bit do not have even parity.
    function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

    localparam logic [15:0] DIV_9600   = div_for(32'd9600);
    localparam logic [15:0] DIV_19200  = div_for(32'd19200);
    localparam logic [15:0] DIV_115200 = div_for(32'd115200);
    localparam logic [15:0] DIV_256000 = div_for(32'd256000);

    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic [2:0]  state_r, state_nxt_s;
    logic [15:0] div_r, div_sel_s, tick_cnt_r;
    logic [3:0]  os_cnt_r, os_target_s;
    logic        tick_s, sample_s, fall_s, start_s;
    logic [2:0]  bit_cnt_r, data_n_r;
    logic [1:0]  stop_cnt_r, stop_n_r;
    logic        par_en_r;
    logic [7:0]  shift_r, aligned_s;
    logic        par_err_acc_r, frame_err_acc_r;
    logic        last_data_s, last_stop_s;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r, parity_err_r, frame_err_r, busy_r;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Divisor lookup for the currently selected baud rate.
    always_comb begin
        div_sel_s = DIV_9600;
        case (baud_sel_i)
            2'd0:    div_sel_s = DIV_9600;
            2'd1:    div_sel_s = DIV_19200;
            2'd2:    div_sel_s = DIV_115200;
            2'd3:    div_sel_s = DIV_256000;
            default: div_sel_s = DIV_9600;
        endcase
    end

    // Tick/sample qualifiers; the start bit is sampled after half a bit, all others after a full bit.
    always_comb begin
        fall_s      = rx_prev_r & ~rx_sync_r;
        start_s     = enable_i & fall_s & (state_r == ST_IDLE);
        tick_s      = (tick_cnt_r == (div_r - 16'd1));
        os_target_s = (state_r == ST_START) ? 4'd7 : 4'd15;
        sample_s    = tick_s & (os_cnt_r == os_target_s);
        last_data_s = (bit_cnt_r == data_n_r);
        last_stop_s = (stop_cnt_r == stop_n_r);
        aligned_s   = shift_r >> (3'd7 - data_n_r);
    end

    // Next-state logic; dropping enable aborts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) state_nxt_s = ST_START;
                    else        state_nxt_s = ST_IDLE;
                end
                ST_START: begin
                    if (sample_s) state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
                    else          state_nxt_s = ST_START;
                end
                ST_DATA: begin
                    if (sample_s && last_data_s) state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
                    else                         state_nxt_s = ST_DATA;
                end
                ST_PARITY: begin
                    if (sample_s) state_nxt_s = ST_STOP;
                    else          state_nxt_s = ST_PARITY;
                end
                ST_STOP: begin
                    if (sample_s && last_stop_s) state_nxt_s = ST_IDLE;
                    else                         state_nxt_s = ST_STOP;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register and busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Oversample counters, held at zero in IDLE so bit phase follows the start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_r <= 16'd0;
            os_cnt_r   <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            tick_cnt_r <= 16'd0;
            os_cnt_r   <= 4'd0;
        end else begin
            tick_cnt_r <= tick_s ? 16'd0 : (tick_cnt_r + 16'd1);
            if (tick_s) begin
                os_cnt_r <= sample_s ? 4'd0 : (os_cnt_r + 4'd1);
            end
        end
    end

    // Frame configuration latch, deserialiser, error accumulation and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_r           <= 16'd0;
            par_en_r        <= 1'b0;
            data_n_r        <= 3'd7;
            stop_n_r        <= 2'd0;
            bit_cnt_r       <= 3'd0;
            stop_cnt_r      <= 2'd0;
            shift_r         <= 8'd0;
            par_err_acc_r   <= 1'b0;
            frame_err_acc_r <= 1'b0;
            rx_data_r       <= 8'd0;
            rx_valid_r      <= 1'b0;
            parity_err_r    <= 1'b0;
            frame_err_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (start_s) begin
                div_r           <= div_sel_s;
                par_en_r        <= parity_en_i;
                data_n_r        <= {1'b1, data_cfg_i};
                stop_n_r        <= (stop_cfg_i == 2'd3) ? 2'd0 : stop_cfg_i;
                bit_cnt_r       <= 3'd0;
                stop_cnt_r      <= 2'd0;
                par_err_acc_r   <= 1'b0;
                frame_err_acc_r <= 1'b0;
            end else if (enable_i && sample_s) begin
                case (state_r)
                    ST_DATA: begin
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: begin
                        par_err_acc_r <= even_parity_err(aligned_s, rx_sync_r);
                    end
                    ST_STOP: begin
                        frame_err_acc_r <= frame_err_acc_r | ~rx_sync_r;
                        stop_cnt_r      <= stop_cnt_r + 2'd1;
                        if (last_stop_s) begin
                            rx_valid_r   <= 1'b1;
                            rx_data_r    <= aligned_s;
                            parity_err_r <= par_err_acc_r;
                            frame_err_r  <= frame_err_acc_r | ~rx_sync_r;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_data_o    = rx_data_r;
    assign rx_valid_o   = rx_valid_r;
    assign parity_err_o = parity_err_r;
    assign frame_err_o  = frame_err_r;
    assign busy_o       = busy_r;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive datapath of the FPGA UART. Sits directly downstream of the `uart_rx_i` pin and upstream of the CPU-visible RX data register in `uart_top`. Samples the line at 16x the selected baud rate and deserialises 5–8 data bits, an optional even-parity bit and 1–3 stop bits. Presents each received word as a one-cycle valid pulse with parity and framing error flags.

## Interface
- `TOP_CLK_FREQ_HZ`, default 50_000_000: system clock frequency used to derive the oversample divisor.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_i` in 1: raw serial line, asynchronous to `clk_i`, idle high.
- `enable_i` in 1: receiver enable (control register RX enable bit).
- `baud_sel_i` in 2: baud select. 0=9600, 1=19200, 2=115200, 3=256000.
- `parity_en_i` in 1: 1 = an even-parity bit follows the data bits.
- `stop_cfg_i` in 2: stop bits. 0=1, 1=2, 2=3, 3=reserved (treated as 1).
- `data_cfg_i` in 2: data bits. 0=5, 1=6, 2=7, 3=8.
- `rx_data_o` out 8: received word, LSB first on the line, right-aligned, unused upper bits 0.
- `rx_valid_o` out 1: one-cycle pulse, word and flags valid.
- `parity_err_o` out 1: parity mismatch for the current word; qualified by `rx_valid_o`.
- `frame_err_o` out 1: any stop bit sampled low; qualified by `rx_valid_o`.
- `busy_o` out 1: high from start-bit detection until return to IDLE.

## Operation
- Input synchroniser: 2-FF, reset value 1. The edge detector compares synced and previous synced values.
- Oversample tick generator:
  - Divisor D = (TOP_CLK_FREQ_HZ + 8·baud) / (16·baud), integer division. At 50 MHz: 326 / 163 / 27 / 12.
  - Counter runs 0..D-1 and emits a one-cycle tick at D-1.
  - It is cleared in IDLE so that phase is aligned to the start edge.
- Configuration (baud, parity, stop, data) is latched on start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: with `enable_i`=1 and a synced falling edge → START, clear tick and sample counters.
  - START: after 8 ticks (bit centre), sample the line. If 1 → false start, back to IDLE with no output. If 0 → DATA.
  - DATA: sample every 16 ticks. Shift in LSB first until N bits are captured. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: sample once at bit centre. Error if the XOR of the data bits and the parity bit ≠ 0.
  - STOP: sample each stop bit at its centre; any 0 sets the frame error. After the last stop-bit sample → IDLE and pulse `rx_valid_o`. Re-arming at the centre of the last stop bit allows back-to-back frames.
- `enable_i`=0 in any state aborts to IDLE next cycle: no valid pulse, `rx_data_o` unchanged.
- `rx_data_o`, `parity_err_o` and `frame_err_o` update together with the valid pulse and hold until the next one.
- No backpressure: the consumer must accept the word in the pulse cycle.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, `parity_err_o`=0, `frame_err_o`=0, `busy_o`=0, FSM=IDLE.
- Start detection occurs 2–3 clocks after the falling edge on `rx_i` (synchroniser plus edge register). `busy_o` rises the cycle after detection.
- Centre of the last stop bit = detection + D·(8 + 16·(N + P + S)) clocks, ±1 clock.
- `rx_valid_o` is asserted exactly 1 clock after the tick that samples the last stop bit. `busy_o` falls in the same cycle.
- A new falling edge in the cycle `rx_valid_o` is high is accepted as a new start.
- Reset assertion mid-frame returns all outputs to reset values immediately (asynchronous).

## Test plan
- 8N1 at 9600 (D=326), line sends 0xA5 → one `rx_valid_o` pulse, `rx_data_o`=0xA5, both error flags 0, pulse within ±2 clocks of start + 326·152.
- 5E2 at 256000 (D=12), sends 0x13 with correct even-parity bit 1 → `rx_data_o`=0x13, `parity_err_o`=0. Repeat with parity bit 0 → `parity_err_o`=1.
- 7N3 at 115200, second stop bit forced low → `rx_valid_o` pulses with `rx_data_o`=sent value and `frame_err_o`=1.
- 40-clock low glitch on idle line at 9600 (shorter than a half bit) → no `rx_valid_o`, `busy_o` returns to 0 after the START sample.
- Two back-to-back 8N1 frames 0x00 then 0xFF with no idle gap → two pulses, data 0x00 then 0xFF, no errors.
- `enable_i` dropped during DATA, or `rst_ni` pulsed mid-frame → no pulse, FSM IDLE. The next complete frame (0x3C) is received correctly.
